btn_event: RTL and testbench

Button event classifier placed directly downstream of the switch debouncer. It consumes the debouncer's clean level `db` and turns each press/release sequence into one-cycle event pulses: press, release, short press, long press and double click. It also provides a long-hold level. Its outputs drive the mode/menu control logic.

---
 rtl/btn_event.sv | 144 ++++++++++++++
 tb/tb_btn_event.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event
//  Brief    : Button event classifier fed by the debounced level `db`.
//             Turns each press/release sequence into one-cycle event pulses:
//             press, release, short press, long press and double click,
//             and provides a long-hold level. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
//  Note: the release pulse port is named `rel` because `release` is a
//  reserved word in SystemVerilog (force/release).
// ============================================================================
module btn_event #(
  parameter int CW       = 26,
  parameter int LONG_CYC = 25_000_000,
  parameter int DBL_CYC  = 12_500_000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       db,
  output logic       press,
  output logic       rel,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       held,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DOWN1 = 3'd1,
    S_LONG  = 3'd2,
    S_WAIT2 = 3'd3,
    S_DOWN2 = 3'd4
  } state_t;

  // Terminal counts: the transition happens when the counter already holds
  // LAST, which places the pulse exactly *_CYC cycles after the start pulse.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        cur_state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          press_next;
  logic          rel_next;
  logic          short_next;
  logic          long_next;
  logic          dbl_next;

  // State, counter and registered event outputs; async active-low clear.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      cur_state    <= S_IDLE;
      cnt          <= '0;
      press        <= 1'b0;
      rel          <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      cur_state    <= next_state;
      cnt          <= cnt_next;
      press        <= press_next;
      rel          <= rel_next;
      short_press  <= short_next;
      long_press   <= long_next;
      double_click <= dbl_next;
      held         <= (next_state == S_LONG);
    end
  end

  // Next-state, counter and pulse decode; the db edge always takes priority
  // over a counter reaching its terminal value in the same cycle.
  always_comb begin
    next_state = cur_state;
    cnt_next   = cnt;
    press_next = 1'b0;
    rel_next   = 1'b0;
    short_next = 1'b0;
    long_next  = 1'b0;
    dbl_next   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (db) begin
          next_state = S_DOWN1;
          cnt_next   = '0;
          press_next = 1'b1;
        end
      end
      S_DOWN1: begin
        if (!db) begin
          next_state = S_WAIT2;
          cnt_next   = '0;
          rel_next   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          next_state = S_LONG;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_LONG: begin
        // A long gesture ends on release without a short press.
        if (!db) begin
          next_state = S_IDLE;
          rel_next   = 1'b1;
        end
      end
      S_WAIT2: begin
        if (db) begin
          next_state = S_DOWN2;
          press_next = 1'b1;
          dbl_next   = 1'b1;
        end else if (cnt == DBL_LAST) begin
          next_state = S_IDLE;
          short_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_DOWN2: begin
        // Holding the second press is neither long nor a third click.
        if (!db) begin
          next_state = S_IDLE;
          rel_next   = 1'b1;
        end
      end
      default: begin
        // Corrupted encodings recover silently.
        next_state = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event
//  Brief    : Self-checking bench for btn_event (LONG_CYC=8, DBL_CYC=5).
//             Expected event pulses are queued with their cycle index when a
//             db pattern is built and popped as the DUT produces output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_DBL   = 5'b00001;

  typedef struct {
    int         t;
    logic [4:0] ev;
  } exp_t;

  logic       ck = 1'b0;
  logic       reset;
  logic       db;
  logic       press;
  logic       rel;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic       held;
  logic [2:0] state;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  btn_event #(
    .CW       (8),
    .LONG_CYC (8),
    .DBL_CYC  (5)
  ) dut (
    .ck           (ck),
    .reset        (reset),
    .db           (db),
    .press        (press),
    .rel          (rel),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held),
    .state        (state)
  );

  always #5 ck = ~ck;

  function automatic logic [4:0] events();
    return {press, rel, short_press, long_press, double_click};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    db    = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({events(), held, state} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_immediate got %b want 000000000", {events(), held, state});
    end
    repeat (2) @(negedge ck);
    n_checks++;
    if ({events(), held, state} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b want 000000000", {events(), held, state});
    end
    reset = 1'b1;
    @(negedge ck);
    n_checks++;
    if ({events(), held, state} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 000000000", {events(), held, state});
    end
  endtask

  task automatic test_short_click();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    repeat (3) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{3, EV_REL});
    sb.push_back('{8, EV_SHORT});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL short_click events t=%0d got %b want %b", t, events(), exp_ev);
      end
      n_checks++;
      if (held !== 1'b0) begin
        n_fail++;
        $display("FAIL short_click held t=%0d got %b want 0", t, held);
      end
      if (t == 3 || t == 8) begin
        n_checks++;
        if (state !== ((t == 3) ? 3'd3 : 3'd0)) begin
          n_fail++;
          $display("FAIL short_click state t=%0d got %0d want %0d", t, state, (t == 3) ? 3 : 0);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL short_click leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_long_hold();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    logic       exp_held;
    repeat (20) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{8, EV_LONG});
    sb.push_back('{20, EV_REL});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      exp_held = (t >= 8 && t < 20);
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL long_hold events t=%0d got %b want %b", t, events(), exp_ev);
      end
      n_checks++;
      if (held !== exp_held) begin
        n_fail++;
        $display("FAIL long_hold held t=%0d got %b want %b", t, held, exp_held);
      end
      if (t == 12 || t == 20) begin
        n_checks++;
        if (state !== ((t == 12) ? 3'd2 : 3'd0)) begin
          n_fail++;
          $display("FAIL long_hold state t=%0d got %0d want %0d", t, state, (t == 12) ? 2 : 0);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL long_hold leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_double_click();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    logic [2:0] exp_st;
    repeat (2) pat.push_back(1'b1);
    repeat (3) pat.push_back(1'b0);
    repeat (2) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{2, EV_REL});
    sb.push_back('{5, EV_PRESS | EV_DBL});
    sb.push_back('{7, EV_REL});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      exp_st = (t < 2) ? 3'd1 : (t < 5) ? 3'd3 : (t < 7) ? 3'd4 : 3'd0;
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL double_click events t=%0d got %b want %b", t, events(), exp_ev);
      end
      n_checks++;
      if (state !== exp_st || held !== 1'b0) begin
        n_fail++;
        $display("FAIL double_click state/held t=%0d got %0d/%b want %0d/0", t, state, held, exp_st);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL double_click leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Release sampled when cnt==7 in DOWN1 must go to WAIT2, not LONG.
  task automatic test_release_at_limit();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    repeat (8) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{8, EV_REL});
    sb.push_back('{13, EV_SHORT});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      n_checks++;
      if (events() !== exp_ev || held !== 1'b0) begin
        n_fail++;
        $display("FAIL release_at_limit events/held t=%0d got %b/%b want %b/0", t, events(), held, exp_ev);
      end
      if (t == 7 || t == 8) begin
        n_checks++;
        if (state !== ((t == 7) ? 3'd1 : 3'd3)) begin
          n_fail++;
          $display("FAIL release_at_limit state t=%0d got %0d want %0d", t, state, (t == 7) ? 1 : 3);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL release_at_limit leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Re-press sampled when cnt==4 in WAIT2 is still a double click.
  task automatic test_repress_at_limit();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    repeat (2) pat.push_back(1'b1);
    repeat (5) pat.push_back(1'b0);
    repeat (2) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{2, EV_REL});
    sb.push_back('{7, EV_PRESS | EV_DBL});
    sb.push_back('{9, EV_REL});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL repress_at_limit events t=%0d got %b want %b", t, events(), exp_ev);
      end
      if (t == 7 || t == 9) begin
        n_checks++;
        if (state !== ((t == 7) ? 3'd4 : 3'd0)) begin
          n_fail++;
          $display("FAIL repress_at_limit state t=%0d got %0d want %0d", t, state, (t == 7) ? 4 : 0);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL repress_at_limit leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // One cycle too late: short_press fires, then the press starts a new gesture.
  task automatic test_repress_too_late();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    repeat (2) pat.push_back(1'b1);
    repeat (6) pat.push_back(1'b0);
    repeat (2) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{2, EV_REL});
    sb.push_back('{7, EV_SHORT});
    sb.push_back('{8, EV_PRESS});
    sb.push_back('{10, EV_REL});
    sb.push_back('{15, EV_SHORT});
    for (int t = 0; t < pat.size(); t++) begin
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL repress_too_late events t=%0d got %b want %b", t, events(), exp_ev);
      end
      if (t == 7 || t == 8) begin
        n_checks++;
        if (state !== ((t == 7) ? 3'd0 : 3'd1)) begin
          n_fail++;
          $display("FAIL repress_too_late state t=%0d got %0d want %0d", t, state, (t == 7) ? 0 : 1);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL repress_too_late leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Reset at cnt==6 in DOWN1 with db held; the restart counts from zero.
  task automatic test_reset_mid_gesture();
    bit         pat[$];
    exp_t       e;
    logic [4:0] exp_ev;
    logic       exp_held;
    repeat (17) pat.push_back(1'b1);
    repeat (10) pat.push_back(1'b0);
    sb.push_back('{0, EV_PRESS});
    sb.push_back('{7, EV_PRESS});
    sb.push_back('{15, EV_LONG});
    sb.push_back('{17, EV_REL});
    for (int t = 0; t < pat.size(); t++) begin
      if (t == 7) begin
        reset = 1'b0;
        #1;
        n_checks++;
        if ({events(), held, state} !== 9'b0) begin
          n_fail++;
          $display("FAIL reset_mid immediate got %b want 000000000", {events(), held, state});
        end
        @(negedge ck);
        n_checks++;
        if ({events(), held, state} !== 9'b0) begin
          n_fail++;
          $display("FAIL reset_mid held_low got %b want 000000000", {events(), held, state});
        end
        reset = 1'b1;
      end
      db = pat[t];
      @(negedge ck);
      exp_ev = 5'b0;
      if (sb.size() > 0 && sb[0].t == t) begin e = sb.pop_front(); exp_ev = e.ev; end
      exp_held = (t >= 15 && t < 17);
      n_checks++;
      if (events() !== exp_ev) begin
        n_fail++;
        $display("FAIL reset_mid events t=%0d got %b want %b", t, events(), exp_ev);
      end
      n_checks++;
      if (held !== exp_held) begin
        n_fail++;
        $display("FAIL reset_mid held t=%0d got %b want %b", t, held, exp_held);
      end
      if (t == 7 || t == 17) begin
        n_checks++;
        if (state !== ((t == 7) ? 3'd1 : 3'd0)) begin
          n_fail++;
          $display("FAIL reset_mid state t=%0d got %0d want %0d", t, state, (t == 7) ? 1 : 0);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid leftover got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_hold();
    test_double_click();
    test_release_at_limit();
    test_repress_at_limit();
    test_repress_too_late();
    test_reset_mid_gesture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
